// File: rtl/rv_pkg.sv
// Shared RV fetch-path types and constants.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; head is shown combinationally.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  entry_t      wdata,
    input  logic        pop,
    output entry_t      rdata,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // Storage needs no reset; on a full push+pop the old head is read before being overwritten.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && empty && !flush));

endmodule

// File: rtl/if_prefetch_unit.sv
// Sequential instruction prefetcher: credit-limited fetch requests, in-order prefetch buffer,
// one instruction per cycle to decode with stall and redirect (flush) handling.
module if_prefetch_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    import rv_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH);
    localparam logic [CW+1:0] CREDIT_LIMIT = (CW + 2)'(DEPTH);

    typedef logic [CW:0] cnt_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    cnt_t            outstanding_q, outstanding_d;
    cnt_t            discard_q, discard_d;
    logic            started_q;

    logic            fire;
    logic            rsp_accept;
    logic            pop;
    logic [CW+1:0]   credits_used;
    cnt_t            fifo_count, pcq_count;
    logic            fifo_full, fifo_empty, pcq_full, pcq_empty;
    fetch_entry_t    head, push_entry;
    logic [XLEN-1:0] pcq_head;
    logic            unused_flags;

    always_comb begin
        credits_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req_valid = !reset && started_q && (credits_used < CREDIT_LIMIT);
        fire           = imem_req_valid && imem_req_ready;
        inst_valid     = !reset && !fifo_empty;
        pop            = inst_valid && !stall && !redirect;
        rsp_accept     = imem_rsp_valid && (discard_q == '0) && !redirect;
        push_entry     = '{pc: pcq_head, inst: imem_rsp_data};
        inst           = inst_valid ? head.inst : NOP_INST;
        inst_pc        = inst_valid ? head.pc : '0;

        outstanding_d = outstanding_q + cnt_t'(fire) - cnt_t'(imem_rsp_valid);

        // Stale words are a subset of outstanding, so after a redirect every word still in
        // flight (including one issued this cycle) becomes stale.
        discard_d = discard_q;
        if (redirect) begin
            discard_d = outstanding_d;
        end else if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - cnt_t'(1);
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            started_q     <= 1'b1;
        end
    end

    assign imem_req_addr = fetch_pc_q;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_prefetch_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (rsp_accept),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // PCs of live requests, in issue order; stale requests were flushed from here on redirect.
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [XLEN-1:0])
    ) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (fire && !redirect),
        .wdata (fetch_pc_q),
        .pop   (rsp_accept),
        .rdata (pcq_head),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    assign unused_flags = ^{pcq_count, pcq_full, pcq_empty, fifo_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed and randomised checks of if_prefetch_unit against a memory model and a PC scoreboard.
module tb_if_prefetch_unit;

    import rv_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst, inst_pc;

    always #5 clk = ~clk;

    if_prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc, last_due, n_out;
    int          ready_mode, lat_min, lat_max;
    logic [31:0] exp_addr, prev_addr;
    bit          prev_stuck;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model memory, check outputs, advance models, then step to posedge+1.
    task automatic cycle();
        logic        fire;
        logic [31:0] pc;
        int          due;
        case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'($urandom_range(0, 1));
            default: imem_req_ready = 1'b0;
        endcase
        fire = imem_req_valid && imem_req_ready;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_addr);
        if (prev_stuck) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (inst_valid) begin
            if (!stall && !redirect) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    pc = sb.pop_front();
                    check("inst_pc", inst_pc, pc);
                    check("inst", inst, mem_word(pc));
                    n_out++;
                end
            end
        end else begin
            check("bubble_inst", inst, NOP_INST);
            check("bubble_pc", inst_pc, 32'h0);
        end
        if (fire) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{due, mem_word(imem_req_addr)});
            sb.push_back(imem_req_addr);
        end
        if (redirect) begin
            sb.delete();
            exp_addr = {redirect_pc[31:2], 2'b00};
        end else if (fire) begin
            exp_addr = exp_addr + 32'd4;
        end
        prev_stuck = imem_req_valid && !imem_req_ready && !redirect;
        prev_addr  = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_inst_valid", 32'(inst_valid), 32'd0);
            check("rst_inst", inst, NOP_INST);
            check("rst_inst_pc", inst_pc, 32'h0);
        end
        pend.delete();
        sb.delete();
        exp_addr   = RESET_PC;
        prev_stuck = 1'b0;
        last_due   = -1;
        cyc        = 0;
        reset      = 1'b0;
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("post_rst_inst_valid", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          first_iv, start_out;
        logic [31:0] hold_inst, hold_pc, first_pc;
        bit          got, after_wrap, wrap_seen;

        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        n_out = 0;

        // 1: sequential fetch, latency 1
        ready_mode = 0; lat_min = 1; lat_max = 1;
        do_reset(2);
        first_iv = -1;
        for (int i = 0; i < 12; i++) begin
            if (inst_valid && first_iv < 0) first_iv = cyc;
            cycle();
        end
        check("first_inst_cycle", 32'(first_iv), 32'd3);
        check("t1_out_count", 32'(n_out), 32'd6);

        // 2: stall holds output while credits run out
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (inst_valid) got = 1'b1;
            else cycle();
        end
        check("t2_valid_before_stall", 32'(got), 32'd1);
        stall = 1'b1;
        hold_inst = inst;
        hold_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_inst", inst, hold_inst);
            check("stall_pc", inst_pc, hold_pc);
            cycle();
        end
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_buffered", 32'(sb.size()), DEPTH);
        stall = 1'b0;
        start_out = n_out;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_drained", 32'(n_out - start_out >= DEPTH), 32'd1);

        // 3: redirect with two requests outstanding
        lat_min = 3; lat_max = 3;
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle();
        check("t3_credits_full", 32'(imem_req_valid), 32'd0);
        check("t3_in_flight", 32'(sb.size()), 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        check("t3_flush_valid", 32'(inst_valid), 32'd0);
        check("t3_new_addr", imem_req_addr, 32'h100);
        got = 1'b0;
        first_pc = 32'h0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (inst_valid) begin
                got = 1'b1;
                first_pc = inst_pc;
            end else begin
                cycle();
            end
        end
        check("t3_got_inst", 32'(got), 32'd1);
        check("t3_first_pc", first_pc, 32'h100);
        for (int i = 0; i < 10; i++) cycle();

        // 4: redirect coincides with a response and a fire; low address bits ignored
        lat_min = 1; lat_max = 1;
        do_reset(1);
        cycle();
        cycle();
        check("t4_fire_at_redirect", 32'(imem_req_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h203;
        cycle();
        redirect = 1'b0;
        check("t4_flush_valid", 32'(inst_valid), 32'd0);
        check("t4_new_addr", imem_req_addr, 32'h200);
        got = 1'b0;
        first_pc = 32'h0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (inst_valid) begin
                got = 1'b1;
                first_pc = inst_pc;
            end else begin
                cycle();
            end
        end
        check("t4_got_inst", 32'(got), 32'd1);
        check("t4_first_pc", first_pc, 32'h200);
        start_out = n_out;
        for (int i = 0; i < 20; i++) cycle();
        check("t4_stream_resumed", 32'(n_out - start_out >= 8), 32'd1);

        // 5: random ready, latency and stall
        ready_mode = 1; lat_min = 1; lat_max = 3;
        do_reset(1);
        start_out = n_out;
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 4) == 0);
            cycle();
        end
        stall = 1'b0;
        check("t5_throughput", 32'(n_out - start_out >= 30), 32'd1);

        // 6: address wrap, then reset mid-burst
        ready_mode = 0; lat_min = 1; lat_max = 1;
        do_reset(1);
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        after_wrap = 1'b0;
        wrap_seen = 1'b0;
        for (int i = 0; i < 20 && !wrap_seen; i++) begin
            if (imem_req_valid) begin
                if (after_wrap) begin
                    check("wrap_addr", imem_req_addr, 32'h0);
                    wrap_seen = 1'b1;
                end else if (imem_req_addr == 32'hFFFF_FFFC) begin
                    after_wrap = 1'b1;
                end
            end
            if (!wrap_seen) cycle();
        end
        check("wrap_seen", 32'(wrap_seen), 32'd1);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) cycle();
        do_reset(1);
        cycle();
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("mid_rst_addr", imem_req_addr, RESET_PC);
        check("mid_rst_inst", inst, NOP_INST);
        check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 15; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
